// File: rtl/lic_traffic_gen_pkg.sv
// Shared definitions for the LIC traffic generator: register map, CTRL/STATUS bits and FSM states.
package lic_traffic_gen_pkg;

  localparam logic [2:0] RegCtrl     = 3'd0;
  localparam logic [2:0] RegBase     = 3'd1;
  localparam logic [2:0] RegStride   = 3'd2;
  localparam logic [2:0] RegLen      = 3'd3;
  localparam logic [2:0] RegStatus   = 3'd4;
  localparam logic [2:0] RegChecksum = 3'd5;
  localparam logic [2:0] RegWpattern = 3'd6;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlModeBit   = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  typedef enum logic [1:0] {TG_IDLE, TG_RUN, TG_DRAIN, TG_DONE} tg_state_e;

endpackage

// File: rtl/lic_traffic_gen_regs.sv
// Peripheral slave for the traffic generator: address decode, configuration registers and the
// single-cycle response pipeline.
module lic_traffic_gen_regs
  import lic_traffic_gen_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_req_i,
  input  logic [AW-1:0]       cfg_add_i,
  input  logic                cfg_wen_i,
  input  logic [DW-1:0]       cfg_wdata_i,
  input  logic [ID_WIDTH-1:0] cfg_id_i,
  output logic                cfg_r_valid_o,
  output logic [DW-1:0]       cfg_r_rdata_o,
  output logic [ID_WIDTH-1:0] cfg_r_id_o,
  input  logic                busy_i,
  input  logic                done_i,
  input  logic [DW-1:0]       checksum_i,
  output logic                start_o,
  output logic                mode_o,
  output logic [AW-1:0]       base_o,
  output logic [AW-1:0]       stride_o,
  output logic [DW-1:0]       len_o,
  output logic [DW-1:0]       wpattern_o
);

  logic [2:0]          reg_idx;
  logic                wr_ok;
  logic                rd_en;
  logic                mode_q, mode_d;
  logic [AW-1:0]       base_q, base_d;
  logic [AW-1:0]       stride_q, stride_d;
  logic [DW-1:0]       len_q, len_d;
  logic [DW-1:0]       wpattern_q, wpattern_d;
  logic [DW-1:0]       rdata_mux;
  logic [DW-1:0]       rdata_q;
  logic                r_valid_q;
  logic [ID_WIDTH-1:0] r_id_q;
  logic                unused_add;

  assign reg_idx    = cfg_add_i[4:2];
  assign unused_add = ^{cfg_add_i[AW-1:5], cfg_add_i[1:0]};
  // Configuration is frozen while the engine runs.
  assign wr_ok      = cfg_req_i & ~cfg_wen_i & ~busy_i;
  assign rd_en      = cfg_req_i & cfg_wen_i;
  assign start_o    = wr_ok & (reg_idx == RegCtrl) & cfg_wdata_i[CtrlStartBit];

  always_comb begin
    mode_d     = mode_q;
    base_d     = base_q;
    stride_d   = stride_q;
    len_d      = len_q;
    wpattern_d = wpattern_q;
    if (wr_ok) begin
      case (reg_idx)
        RegCtrl:     mode_d     = cfg_wdata_i[CtrlModeBit];
        RegBase:     base_d     = AW'(cfg_wdata_i);
        RegStride:   stride_d   = AW'(cfg_wdata_i);
        RegLen:      len_d      = cfg_wdata_i;
        RegWpattern: wpattern_d = cfg_wdata_i;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (reg_idx)
      RegCtrl:     rdata_mux[CtrlModeBit] = mode_q;
      RegBase:     rdata_mux = DW'(base_q);
      RegStride:   rdata_mux = DW'(stride_q);
      RegLen:      rdata_mux = len_q;
      RegStatus: begin
        rdata_mux[StatusBusyBit] = busy_i;
        rdata_mux[StatusDoneBit] = done_i;
      end
      RegChecksum: rdata_mux = checksum_i;
      RegWpattern: rdata_mux = wpattern_q;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      base_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      wpattern_q <= '0;
      rdata_q    <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      wpattern_q <= wpattern_d;
      r_valid_q  <= cfg_req_i;
      rdata_q    <= rd_en ? rdata_mux : '0;
      if (cfg_req_i) begin
        r_id_q <= cfg_id_i;
      end
    end
  end

  assign cfg_r_valid_o = r_valid_q;
  assign cfg_r_rdata_o = rdata_q;
  assign cfg_r_id_o    = r_id_q;
  assign mode_o        = mode_q;
  assign base_o        = base_q;
  assign stride_o      = stride_q;
  assign len_o         = len_q;
  assign wpattern_o    = wpattern_q;

endmodule

// File: rtl/lic_traffic_gen_engine.sv
// Traffic-generator core: issues pipelined TCDM reads/writes over a strided address range,
// XOR-accumulates read data and pulses evt_o on completion.
module lic_traffic_gen_engine
  import lic_traffic_gen_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_req,
  output logic                cfg_gnt,
  input  logic [AW-1:0]       cfg_add,
  input  logic                cfg_wen,
  input  logic [DW-1:0]       cfg_wdata,
  input  logic [ID_WIDTH-1:0] cfg_id,
  output logic                cfg_r_valid,
  output logic [DW-1:0]       cfg_r_rdata,
  output logic [ID_WIDTH-1:0] cfg_r_id,
  output logic                tcdm_req,
  input  logic                tcdm_gnt,
  output logic [AW-1:0]       tcdm_add,
  output logic                tcdm_wen,
  output logic [DW-1:0]       tcdm_wdata,
  output logic [DW/8-1:0]     tcdm_be,
  input  logic                tcdm_r_valid,
  input  logic [DW-1:0]       tcdm_r_rdata,
  output logic                evt_o,
  output logic                busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  tg_state_e     state_q, state_d;
  logic [AW-1:0] issued_q, issued_d;
  logic [AW-1:0] resp_q, resp_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic          done_q, done_d;
  logic          evt_q, evt_d;

  logic          start;
  logic          mode;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [DW-1:0] len;
  logic [DW-1:0] wpattern;
  logic [AW-1:0] len_aw;
  logic          can_issue;
  logic          hs;
  logic          rsp;

  assign cfg_gnt = cfg_req;

  lic_traffic_gen_regs #(
    .ID_WIDTH (ID_WIDTH),
    .DW       (DW),
    .AW       (AW)
  ) u_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_req_i     (cfg_req),
    .cfg_add_i     (cfg_add),
    .cfg_wen_i     (cfg_wen),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_id_i      (cfg_id),
    .cfg_r_valid_o (cfg_r_valid),
    .cfg_r_rdata_o (cfg_r_rdata),
    .cfg_r_id_o    (cfg_r_id),
    .busy_i        (busy_o),
    .done_i        (done_q),
    .checksum_i    (checksum_q),
    .start_o       (start),
    .mode_o        (mode),
    .base_o        (base),
    .stride_o      (stride),
    .len_o         (len),
    .wpattern_o    (wpattern)
  );

  assign len_aw    = AW'(len);
  assign busy_o    = (state_q == TG_RUN) || (state_q == TG_DRAIN);
  assign can_issue = (state_q == TG_RUN) && (issued_q < len_aw) && (outst_q < OW'(MAX_OUTST));
  assign hs        = can_issue & tcdm_gnt;
  // A response with nothing in flight is stale and must not disturb the counters.
  assign rsp       = tcdm_r_valid & (outst_q != '0);

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    resp_d     = resp_q;
    outst_d    = outst_q;
    addr_d     = addr_q;
    checksum_d = checksum_q;
    done_d     = done_q;
    evt_d      = 1'b0;

    if (hs) begin
      issued_d = issued_q + 1'b1;
      addr_d   = addr_q + stride;
    end
    if (hs && !rsp) begin
      outst_d = outst_q + 1'b1;
    end else if (!hs && rsp) begin
      outst_d = outst_q - 1'b1;
    end
    if (rsp) begin
      resp_d = resp_q + 1'b1;
      if (!mode) begin
        checksum_d = checksum_q ^ tcdm_r_rdata;
      end
    end

    case (state_q)
      TG_IDLE:  ;
      TG_RUN: begin
        if (issued_q == len_aw) begin
          state_d = TG_DRAIN;
        end
      end
      TG_DRAIN: begin
        if (resp_q == len_aw) begin
          state_d = TG_DONE;
        end
      end
      TG_DONE: begin
        evt_d   = 1'b1;
        done_d  = 1'b1;
        state_d = TG_IDLE;
      end
      default: state_d = TG_IDLE;
    endcase

    // start is only raised when not busy, i.e. from IDLE or DONE
    if (start) begin
      state_d    = (len_aw == '0) ? TG_DONE : TG_RUN;
      issued_d   = '0;
      resp_d     = '0;
      outst_d    = '0;
      addr_d     = base;
      checksum_d = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TG_IDLE;
      issued_q   <= '0;
      resp_q     <= '0;
      outst_q    <= '0;
      addr_q     <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      resp_q     <= resp_d;
      outst_q    <= outst_d;
      addr_q     <= addr_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
      evt_q      <= evt_d;
    end
  end

  assign tcdm_req   = can_issue;
  assign tcdm_add   = addr_q;
  assign tcdm_wen   = can_issue & ~mode;
  assign tcdm_wdata = wpattern ^ DW'(issued_q);
  assign tcdm_be    = '1;
  assign evt_o      = evt_q;

endmodule
